cia_tod_seq: RTL and testbench

CIA_TOD_SEQ -- requirements
Module: cia_tod_seq

---
 rtl/cia_tod_seq_pkg.sv | 70 +++++++
 rtl/cia_tod_seq_arb.sv | 39 +++
 rtl/cia_tod_seq.sv | 158 +++++++++++++++
 tb/tb_cia_tod_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cia_tod_seq_pkg.sv
// Package cia: shared CIA types plus the TOD access sequencer additions.
//   reg4_t / reg8_t    : register address and data widths
//   tod_t              : time-of-day value as BCD fields (hh is the single
//                        hours-tens bit, pm the AM/PM flag)
//   TOD_ADDR_*         : TOD register addresses (10ths .. hours)
//   tod_seq_state_e    : sequencer states
//   ARB_SET / ARB_GET  : requester indices on the round-robin arbiter
//   tod_state_addr()   : bus address driven in a given sequencer state
//   tod_write_byte()   : register byte written in a given W_* state
package cia;

  typedef logic [3:0] reg4_t;
  typedef logic [7:0] reg8_t;

  typedef struct packed {
    logic       pm;
    logic       hh;
    logic [3:0] hl;
    logic [2:0] mh;
    logic [3:0] ml;
    logic [2:0] sh;
    logic [3:0] sl;
    logic [3:0] t;
  } tod_t;

  localparam reg4_t TOD_ADDR_TS  = 4'h8;
  localparam reg4_t TOD_ADDR_SEC = 4'h9;
  localparam reg4_t TOD_ADDR_MIN = 4'hA;
  localparam reg4_t TOD_ADDR_HR  = 4'hB;

  localparam int ARB_SET = 0;
  localparam int ARB_GET = 1;

  typedef enum logic [3:0] {
    IDLE,
    W_HR,
    W_MIN,
    W_SEC,
    W_TS,
    R_HR,
    R_MIN,
    R_SEC,
    R_TS
  } tod_seq_state_e;

  function automatic reg4_t tod_state_addr(tod_seq_state_e s);
    reg4_t a;
    case (s)
      W_HR,  R_HR:  a = TOD_ADDR_HR;
      W_MIN, R_MIN: a = TOD_ADDR_MIN;
      W_SEC, R_SEC: a = TOD_ADDR_SEC;
      W_TS,  R_TS:  a = TOD_ADDR_TS;
      default:      a = 4'h0;
    endcase
    return a;
  endfunction

  function automatic reg8_t tod_write_byte(tod_seq_state_e s, tod_t v);
    reg8_t b;
    case (s)
      W_HR:    b = {v.pm, 2'b00, v.hh, v.hl};
      W_MIN:   b = {1'b0, v.mh, v.ml};
      W_SEC:   b = {1'b0, v.sh, v.sl};
      W_TS:    b = {4'b0000, v.t};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cia_tod_seq_arb.sv
// cia_rr_arb2: two-way round-robin arbiter.
//   clk, res  : clock, synchronous active-high reset (pointer favours set)
//   i_req     : request vector, bit ARB_SET = set, bit ARB_GET = get
//   i_accept  : the current grant is being taken this clock
//   o_grant   : one-hot grant (combinational), 0 when nothing requests
// The pointer only moves when a grant is accepted, and it always moves
// away from the requester just served, so a lone requester served twice
// in a row still leaves the other one favoured on the next collision.
module cia_rr_arb2
  import cia::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_favour_get;

  always_comb begin
    o_grant = 2'b00;
    if (i_req == 2'b11) begin
      o_grant[ARB_GET] = r_favour_get;
      o_grant[ARB_SET] = ~r_favour_get;
    end else begin
      o_grant = i_req;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_favour_get <= 1'b0;
    end else if (i_accept && (o_grant != 2'b00)) begin
      r_favour_get <= o_grant[ARB_SET];
    end
  end

endmodule

// File: rtl/cia_tod_seq.sv
// cia_tod_seq: sequences atomic TOD clock/alarm loads and time reads over
// the CIA register bus, one register per PHI2 cycle.
//   clk, res     : clock, synchronous active-high reset
//   phi2_dn      : one-clk strobe at the end of each PHI2 bus cycle
//   set_req      : load request (level until set_done); set_alarm picks
//                  alarm (1) or clock (0); set_val is the value to load
//   get_req      : atomic read request (level until get_done)
//   bus_dout     : register read data
//   bus_rd/we    : read / write strobes; bus_addr, bus_din, bus_w_alarm
//   set_done     : one-clk pulse after the last write
//   get_done     : one-clk pulse after the last read; get_val valid from it
//   get_val      : last time read
//   busy         : a sequence is in progress
// Handshake: a request is a level held by its owner; it is taken on a
// phi2_dn in IDLE and answered by exactly one done pulse 4 PHI2 cycles
// later. The owner may drop the request at any time after acceptance
// without aborting the sequence. Hours go first on both directions so the
// hardware latch freezes on the first access and releases on the 10ths.
module cia_tod_seq
  import cia::*;
(
  input  logic  clk,
  input  logic  res,
  input  logic  phi2_dn,
  input  logic  set_req,
  input  logic  set_alarm,
  input  tod_t  set_val,
  input  logic  get_req,
  input  reg8_t bus_dout,
  output logic  bus_rd,
  output logic  bus_we,
  output reg4_t bus_addr,
  output reg8_t bus_din,
  output logic  bus_w_alarm,
  output logic  set_done,
  output logic  get_done,
  output tod_t  get_val,
  output logic  busy
);

  tod_seq_state_e r_state;
  tod_seq_state_e w_next_state;
  tod_t           r_set_val;
  logic           r_set_alarm;
  logic           r_set_done;
  logic           r_get_done;
  tod_t           r_get_val;
  logic [1:0]     w_req;
  logic [1:0]     w_grant;
  logic           w_accept;

  assign w_req[ARB_SET] = set_req;
  assign w_req[ARB_GET] = get_req;

  // A done pulse still high means the requester has not yet seen it and
  // may still hold its request; masking acceptance here guarantees the
  // next sequence starts no earlier than the strobe after done.
  assign w_accept = (r_state == IDLE) && phi2_dn && !r_set_done &&
                    !r_get_done && (set_req || get_req);

  cia_rr_arb2 u_arb (
    .clk      (clk),
    .res      (res),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_next_state = r_state;
    bus_rd       = 1'b0;
    bus_we       = 1'b0;
    bus_w_alarm  = 1'b0;
    bus_addr     = 4'h0;
    bus_din      = 8'h00;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_grant[ARB_SET] ? W_HR : R_HR;
        end
      end
      W_HR, W_MIN, W_SEC, W_TS: begin
        bus_we      = 1'b1;
        bus_w_alarm = r_set_alarm;
        bus_addr    = tod_state_addr(r_state);
        bus_din     = tod_write_byte(r_state, r_set_val);
        if (phi2_dn) begin
          case (r_state)
            W_HR:    w_next_state = W_MIN;
            W_MIN:   w_next_state = W_SEC;
            W_SEC:   w_next_state = W_TS;
            default: w_next_state = IDLE;
          endcase
        end
      end
      R_HR, R_MIN, R_SEC, R_TS: begin
        bus_rd   = 1'b1;
        bus_addr = tod_state_addr(r_state);
        if (phi2_dn) begin
          case (r_state)
            R_HR:    w_next_state = R_MIN;
            R_MIN:   w_next_state = R_SEC;
            R_SEC:   w_next_state = R_TS;
            default: w_next_state = IDLE;
          endcase
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state     <= IDLE;
      r_set_val   <= '0;
      r_set_alarm <= 1'b0;
      r_set_done  <= 1'b0;
      r_get_done  <= 1'b0;
      r_get_val   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_set_done <= phi2_dn && (r_state == W_TS);
      r_get_done <= phi2_dn && (r_state == R_TS);
      if (w_accept && w_grant[ARB_SET]) begin
        r_set_val   <= set_val;
        r_set_alarm <= set_alarm;
      end
      // Reserved bits of each register byte are simply not stored.
      if (phi2_dn) begin
        case (r_state)
          R_HR: begin
            r_get_val.pm <= bus_dout[7];
            r_get_val.hh <= bus_dout[4];
            r_get_val.hl <= bus_dout[3:0];
          end
          R_MIN: begin
            r_get_val.mh <= bus_dout[6:4];
            r_get_val.ml <= bus_dout[3:0];
          end
          R_SEC: begin
            r_get_val.sh <= bus_dout[6:4];
            r_get_val.sl <= bus_dout[3:0];
          end
          R_TS: begin
            r_get_val.t <= bus_dout[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign set_done = r_set_done;
  assign get_done = r_get_done;
  assign get_val  = r_get_val;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_cia_tod_seq.sv
module tb_cia_tod_seq;
  import cia::*;

  // ---------------- clock / reset / DUT ----------------
  logic  clk = 1'b0;
  logic  res;
  logic  phi2_dn;
  logic  set_req;
  logic  set_alarm;
  tod_t  set_val;
  logic  get_req;
  reg8_t bus_dout;
  logic  bus_rd;
  logic  bus_we;
  reg4_t bus_addr;
  reg8_t bus_din;
  logic  bus_w_alarm;
  logic  set_done;
  logic  get_done;
  tod_t  get_val;
  logic  busy;

  always #5 clk = ~clk;

  cia_tod_seq dut (
    .clk         (clk),
    .res         (res),
    .phi2_dn     (phi2_dn),
    .set_req     (set_req),
    .set_alarm   (set_alarm),
    .set_val     (set_val),
    .get_req     (get_req),
    .bus_dout    (bus_dout),
    .bus_rd      (bus_rd),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_din     (bus_din),
    .bus_w_alarm (bus_w_alarm),
    .set_done    (set_done),
    .get_done    (get_done),
    .get_val     (get_val),
    .busy        (busy)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  int          phi_period = 4;
  int          phi_cnt    = 0;
  reg8_t       rd_mem [16];
  logic [15:0] obs_q [$];     // observed accesses {0,we,rd,alarm,addr,din}
  int          obs_cyc_q [$]; // PHI2 strobe number ending each access
  int          acc_q [$];     // strobe number at which busy rose
  int          sdone_q [$];
  int          gdone_q [$];
  int          idle_viol = 0;
  logic [15:0] exp_q [$];

  typedef struct {
    bit          is_get;
    bit          al;
    tod_t        val;
    logic [31:0] rd;     // bytes returned at B,A,9,8
    logic [31:0] exp_b;  // bytes expected at B,A,9,8 for a set
    tod_t        exp_get;
    string       name;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_set_bytes(tod_t v);
    int hr, mn, sc, ts;
    hr = int'(v.pm) * 128 + int'(v.hh) * 16 + int'(v.hl);
    mn = int'(v.mh) * 16 + int'(v.ml);
    sc = int'(v.sh) * 16 + int'(v.sl);
    ts = int'(v.t);
    return 32'(hr * 16777216 + mn * 65536 + sc * 256 + ts);
  endfunction

  function automatic tod_t model_get(logic [31:0] b);
    tod_t r;
    int hrb, mnb, scb, tsb;
    hrb = int'(b[31:24]);
    mnb = int'(b[23:16]);
    scb = int'(b[15:8]);
    tsb = int'(b[7:0]);
    r.pm = 1'((hrb / 128) % 2);
    r.hh = 1'((hrb / 16) % 2);
    r.hl = 4'(hrb % 16);
    r.mh = 3'((mnb / 16) % 8);
    r.ml = 4'(mnb % 16);
    r.sh = 3'((scb / 16) % 8);
    r.sl = 4'(scb % 16);
    r.t  = 4'(tsb % 16);
    return r;
  endfunction

  function automatic vec_t mk_vec(bit is_get, bit al, tod_t val, logic [31:0] rd,
                                  logic [31:0] exp_b, tod_t exp_get, string name);
    vec_t v;
    v.is_get = is_get; v.al = al; v.val = val; v.rd = rd;
    v.exp_b = exp_b; v.exp_get = exp_get; v.name = name;
    return v;
  endfunction

  // ---------------- PHI2 generator, bus responder, monitor ----------------
  initial begin
    int div;
    div      = 0;
    phi2_dn  = 1'b0;
    bus_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && acc_q.size() >= 0) begin end
      if (busy === 1'b1 && !(obs_q.size() < 0)) begin end
      if (set_done === 1'b1) sdone_q.push_back(phi_cnt);
      if (get_done === 1'b1) gdone_q.push_back(phi_cnt);
      if (busy === 1'b0 && (bus_rd || bus_we || bus_w_alarm || bus_addr != 4'h0 || bus_din != 8'h00))
        idle_viol++;
      div++;
      if (div >= phi_period) begin
        div     = 0;
        phi2_dn = 1'b1;
        phi_cnt++;
        if (bus_we === 1'b1 || bus_rd === 1'b1) begin
          obs_q.push_back({1'b0, bus_we, bus_rd, bus_w_alarm, bus_addr, (bus_we ? bus_din : 8'h00)});
          obs_cyc_q.push_back(phi_cnt);
        end
      end else begin
        phi2_dn = 1'b0;
      end
      bus_dout = rd_mem[bus_addr];
    end
  end

  // Acceptance points: busy rising, stamped with the strobe that caused it.
  initial begin
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy === 1'b1 && prev_busy !== 1'b1) acc_q.push_back(phi_cnt);
      prev_busy = busy;
    end
  end

  task automatic clear_logs();
    obs_q.delete(); obs_cyc_q.delete(); acc_q.delete();
    sdone_q.delete(); gdone_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1; set_req = 1'b0; get_req = 1'b0;
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- one complete transaction ----------------
  task automatic run_txn(input bit is_get, input bit al, input tod_t val,
                         input logic [31:0] rd, input logic [31:0] exp_b,
                         input tod_t exp_get, input bit drop_early, input string name);
    bit got;
    rd_mem[11] = rd[31:24];
    rd_mem[10] = rd[23:16];
    rd_mem[9]  = rd[15:8];
    rd_mem[8]  = rd[7:0];
    @(negedge clk);
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      if (is_get) exp_q.push_back({4'b0010, 4'(11 - k), 8'h00});
      else        exp_q.push_back({1'b0, 1'b1, 1'b0, al, 4'(11 - k), exp_b[31 - 8 * k -: 8]});
    end
    if (is_get) begin
      get_req = 1'b1;
    end else begin
      set_req = 1'b1; set_alarm = al; set_val = val;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (drop_early && busy) begin
        set_req = 1'b0; get_req = 1'b0;
        set_val = ~val; set_alarm = ~al;
      end
      if (is_get ? get_done : set_done) got = 1'b1;
    end
    set_req = 1'b0; get_req = 1'b0;
    check({name, "_done_seen"}, 32'(got), 32'd1);
    if (is_get) check({name, "_get_val"}, 32'(get_val), 32'(exp_get));
    @(negedge clk);
    check({name, "_done_width"}, 32'(is_get ? get_done : set_done), 32'd0);
    check({name, "_other_done"}, 32'(is_get ? sdone_q.size() : gdone_q.size()), 32'd0);
    check({name, "_n_access"}, 32'(obs_q.size()), 32'd4);
    check({name, "_n_accept"}, 32'(acc_q.size()), 32'd1);
    if (obs_q.size() == 4 && acc_q.size() == 1) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("%s_access%0d", name, k), 32'(obs_q[k]), 32'(exp_q[k]));
        check($sformatf("%s_cycle%0d", name, k), 32'(obs_cyc_q[k]), 32'(acc_q[0] + 1 + k));
      end
      if (is_get) begin
        if (gdone_q.size() == 1) check({name, "_latency"}, 32'(gdone_q[0]), 32'(acc_q[0] + 4));
        else check({name, "_n_done"}, 32'(gdone_q.size()), 32'd1);
      end else begin
        if (sdone_q.size() == 1) check({name, "_latency"}, 32'(sdone_q[0]), 32'(acc_q[0] + 4));
        else check({name, "_n_done"}, 32'(sdone_q.size()), 32'd1);
      end
    end
  endtask

  // ---------------- simultaneous requests ----------------
  task automatic run_arb();
    int order [$];
    bit again;
    @(negedge clk);
    clear_logs();
    set_val = tod_t'(24'h123456); set_alarm = 1'b0;
    set_req = 1'b1; get_req = 1'b1; again = 1'b0;
    for (int i = 0; i < 600 && order.size() < 4; i++) begin
      @(negedge clk);
      if (set_done) begin set_req = 1'b0; order.push_back(0); end
      if (get_done) begin get_req = 1'b0; order.push_back(1); end
      if (order.size() == 2 && !again) begin
        again = 1'b1; set_req = 1'b1; get_req = 1'b1;
      end
    end
    set_req = 1'b0; get_req = 1'b0;
    @(negedge clk);
    check("arb_n_done", 32'(order.size()), 32'd4);
    check("arb_n_accept", 32'(acc_q.size()), 32'd4);
    check("arb_n_access", 32'(obs_q.size()), 32'd16);
    if (order.size() == 4)
      for (int k = 0; k < 4; k++) check($sformatf("arb_order%0d", k), 32'(order[k]), 32'(k % 2));
    if (acc_q.size() == 4)
      for (int k = 1; k < 4; k++)
        check($sformatf("arb_idle_gap%0d", k), 32'(acc_q[k] > acc_q[k - 1] + 4), 32'd1);
  endtask

  // ---------------- reset in the middle of a write ----------------
  task automatic run_reset_mid();
    bit hit;
    @(negedge clk);
    set_val = tod_t'(24'hABCDEF); set_alarm = 1'b0; set_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (busy && bus_we && bus_addr == TOD_ADDR_MIN) hit = 1'b1;
    end
    check("rst_reached_w_min", 32'(hit), 32'd1);
    res = 1'b1; set_req = 1'b0;
    clear_logs();
    @(negedge clk);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    res = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_set_done", 32'(sdone_q.size()), 32'd0);
    check("rst_no_access", 32'(obs_q.size()), 32'd0);
  endtask

  // ---------------- main ----------------
  initial begin
    res = 1'b1; set_req = 1'b0; get_req = 1'b0; set_alarm = 1'b0; set_val = '0;
    for (int a = 0; a < 16; a++) rd_mem[a] = 8'h00;

    vecs[0] = mk_vec(1'b0, 1'b0,
      tod_t'{pm:1'b1, hh:1'b1, hl:4'h1, mh:3'h5, ml:4'h9, sh:3'h5, sl:4'h9, t:4'h9},
      32'h0, 32'h91595909, tod_t'(24'h0), "set_pm_11_59_59_9");
    vecs[1] = mk_vec(1'b0, 1'b1,
      tod_t'{pm:1'b0, hh:1'b0, hl:4'h1, mh:3'h0, ml:4'h0, sh:3'h0, sl:4'h0, t:4'h0},
      32'h0, 32'h01000000, tod_t'(24'h0), "set_alarm_01_00_00_0");
    vecs[2] = mk_vec(1'b1, 1'b0, tod_t'(24'h0), 32'h12345607, 32'h0,
      tod_t'{pm:1'b0, hh:1'b1, hl:4'h2, mh:3'h3, ml:4'h4, sh:3'h5, sl:4'h6, t:4'h7},
      "get_12_34_56_7");
    vecs[3] = mk_vec(1'b1, 1'b0, tod_t'(24'h0), 32'hFFFFFFFF, 32'h0,
      tod_t'{pm:1'b1, hh:1'b1, hl:4'hF, mh:3'h7, ml:4'hF, sh:3'h7, sl:4'hF, t:4'hF},
      "get_all_ones");
    vecs[4] = mk_vec(1'b0, 1'b0,
      tod_t'{pm:1'b0, hh:1'b1, hl:4'hF, mh:3'h7, ml:4'hF, sh:3'h7, sl:4'hF, t:4'hF},
      32'h0, 32'h1F7F7F0F, tod_t'(24'h0), "set_non_bcd");
    vecs[5] = mk_vec(1'b1, 1'b0, tod_t'(24'h0), 32'h608080F0, 32'h0,
      tod_t'(24'h0), "get_reserved_only");

    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_set_done", 32'(set_done), 32'd0);
    check("reset_get_done", 32'(get_done), 32'd0);
    check("reset_get_val", 32'(get_val), 32'd0);
    check("reset_bus", 32'({bus_rd, bus_we, bus_w_alarm, bus_addr, bus_din}), 32'd0);

    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].is_get, vecs[v].al, vecs[v].val, vecs[v].rd, vecs[v].exp_b,
              vecs[v].exp_get, 1'b0, vecs[v].name);

    run_txn(1'b1, 1'b0, tod_t'(24'h0), 32'h11223304, 32'h0,
      tod_t'{pm:1'b0, hh:1'b1, hl:4'h1, mh:3'h2, ml:4'h2, sh:3'h3, sl:4'h3, t:4'h4},
      1'b1, "get_drop_req");

    run_reset_mid();
    run_txn(1'b1, 1'b0, tod_t'(24'h0), 32'h92010203, 32'h0,
      model_get(32'h92010203), 1'b0, "get_after_reset");

    do_reset();
    run_arb();

    for (int n = 0; n < 40; n++) begin
      bit          g, al, drop;
      tod_t        val;
      logic [31:0] rd;
      g    = 1'($urandom_range(0, 1));
      al   = 1'($urandom_range(0, 1));
      drop = 1'($urandom_range(0, 1));
      val  = tod_t'($urandom);
      rd   = $urandom;
      phi_period = $urandom_range(2, 5);
      run_txn(g, al, val, rd, model_set_bytes(val), model_get(rd), drop,
              $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    check("idle_outputs_zero", 32'(idle_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
